// File: rtl/tt_pkg.sv
// tt_pkg: shared types and constants for the 7-input truth-table capture engine.
package tt_pkg;
   localparam int TT_NIN = 7;
   localparam int TT_NBITS = 128;
   typedef logic [TT_NBITS-1:0] tt_t;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/tt_capture7_if.sv
// tt_capture7_if: capture engine bus; TT_CAPTURE_CMP_EN adds expected/match.
interface tt_capture7_if;
   import tt_pkg::*;
   logic start;
   logic [TT_NIN-1:0] x;
   logic dut_out;
   logic busy;
   logic done;
   tt_t tt;
`ifdef TT_CAPTURE_CMP_EN
   tt_t expected;
   logic match;
`endif
   modport master (
      input start, dut_out,
      output x, busy, done, tt
`ifdef TT_CAPTURE_CMP_EN
      , input expected, output match
`endif
   );
   modport slave (
      output start, dut_out,
      input x, busy, done, tt
`ifdef TT_CAPTURE_CMP_EN
      , output expected, input match
`endif
   );
endinterface

// File: rtl/tt_tag_pipe.sv
// tt_tag_pipe: DEPTH-deep {valid, index} delay line matching the DUT latency.
module tt_tag_pipe
   import tt_pkg::*;
#(
   parameter int DEPTH = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_v,
   input  logic [TT_NIN-1:0] in_idx,
   output logic              out_v,
   output logic [TT_NIN-1:0] out_idx
);
   if (DEPTH == 0) begin : g_pass
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign out_v = in_v;
      assign out_idx = in_idx;
   end else begin : g_sr
      logic [TT_NIN:0] sr [DEPTH];
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
         else begin
            sr[0] <= {in_v, in_idx};
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
         end
      assign {out_v, out_idx} = sr[DEPTH-1];
   end
endmodule

// File: rtl/tt_capture7.sv
// tt_capture7: sweeps all 128 minterms into a DUT and assembles its truth table.
// TT_CAPTURE_CMP_EN adds a comparator against an expected signature (expected/match).
module tt_capture7
   import tt_pkg::*;
#(
   parameter int DUT_LAT = 0
) (
   input logic           clk,
   input logic           rst_n,
   tt_capture7_if.master bus
);
   localparam logic [3:0] LAT_M1 = 4'(DUT_LAT > 0 ? DUT_LAT - 1 : 0);
   state_t state, state_nx;
   logic [TT_NIN-1:0] cnt, tag_idx;
   logic [3:0] lc;
   logic tag_v, accept;
   tt_t tt_q;
   assign accept = bus.start && (state == IDLE || state == DONE);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = bus.start ? RUN : IDLE;
         RUN:   if (cnt == '1) state_nx = DUT_LAT == 0 ? DONE : DRAIN;
         DRAIN: if (lc == '0) state_nx = DONE;
         DONE:  state_nx = bus.start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      bus.busy = state != IDLE;
      bus.done = state == DONE;
      bus.x = state == IDLE ? '0 : cnt;
   end
   // cnt parks at 127 through DRAIN/DONE so x holds the last minterm
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         lc <= '0;
         tt_q <= '0;
      end else begin
         if (accept) cnt <= '0;
         else if (state == RUN && cnt != '1) cnt <= cnt + 1'b1;
         if (state == RUN) lc <= LAT_M1;
         else if (state == DRAIN) lc <= lc - 1'b1;
         if (accept) tt_q <= '0;
         else if (tag_v) tt_q[tag_idx] <= bus.dut_out;
      end
   assign bus.tt = tt_q;
   tt_tag_pipe #(.DEPTH(DUT_LAT)) u_tag (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_v   (state == RUN),
      .in_idx (cnt),
      .out_v  (tag_v),
      .out_idx(tag_idx)
   );
`ifdef TT_CAPTURE_CMP_EN
   logic match_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) match_q <= 1'b0;
      else if (accept) match_q <= 1'b0;
      else if (state == DONE) match_q <= tt_q == bus.expected;
   assign bus.match = match_q;
`endif
endmodule

// File: tb/tb_tt_capture7.sv
// tb_tt_capture7: directed vectors for tt_capture7 at DUT_LAT=0 and DUT_LAT=3.
module tb_tt_capture7;
   import tt_pkg::*;
   typedef struct {
      int  inst;
      int  fsel;
      tt_t exp_tt;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int sel0 = 0;
   int sel3 = 3;
   int n_cmp = 0;
   int n_err = 0;
   int d0 = 0;
   logic [2:0] p3;
   tt_capture7_if if0();
   tt_capture7_if if3();
   tt_capture7 #(.DUT_LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
   tt_capture7 #(.DUT_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.master));
   always #5 clk = ~clk;
   // 0:x0 1:~x0 2:MAJ(x0,x1,x2) 3:x6 other:MAJ(x0,x1,x3)
   function automatic logic f(input int sel, input logic [6:0] v);
      case (sel)
         0: return v[0];
         1: return ~v[0];
         2: return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
         3: return v[6];
         default: return (v[0] & v[1]) | (v[0] & v[3]) | (v[1] & v[3]);
      endcase
   endfunction
   assign if0.dut_out = f(sel0, if0.x);
   always @(posedge clk) p3 <= {p3[1:0], f(sel3, if3.x)};
   assign if3.dut_out = p3[2];
   always @(posedge clk) if (if0.done) d0 <= d0 + 1;
`ifdef TT_CAPTURE_CMP_EN
   assign if0.expected = {16{8'hE8}};
   assign if3.expected = '0;
`endif
   function automatic logic dn(input int inst);
      return inst == 0 ? if0.done : if3.done;
   endfunction
   function automatic logic bz(input int inst);
      return inst == 0 ? if0.busy : if3.busy;
   endfunction
   function automatic tt_t ttv(input int inst);
      return inst == 0 ? if0.tt : if3.tt;
   endfunction
   task automatic set_start(input int inst, input logic v);
      if (inst == 0) if0.start = v;
      else if3.start = v;
   endtask
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   // Pulses start, then watches 300 cycles; restart_at>0 re-pulses start mid-sweep.
   task automatic sweep(input int inst, input int restart_at, output int done_at,
                        output int busy_cnt, output int ndone, output tt_t got);
      @(negedge clk) set_start(inst, 1'b1);
      @(posedge clk) #1 set_start(inst, 1'b0);
      done_at = -1;
      busy_cnt = 0;
      ndone = 0;
      got = '0;
      for (int n = 1; n <= 300; n++) begin
         if (dn(inst)) begin
            ndone++;
            if (done_at < 0) begin
               done_at = n;
               got = ttv(inst);
            end
         end else if (done_at < 0 && bz(inst)) busy_cnt++;
         if (n == restart_at) set_start(inst, 1'b1);
         @(posedge clk) #1 set_start(inst, 1'b0);
      end
   endtask
   initial begin
      vec_t vt[6];
      int done_at, busy_cnt, ndone, lat, n, m, d_base;
      tt_t got;
      vt[0] = '{0, 0, {32{4'hA}}};
      vt[1] = '{0, 1, {32{4'h5}}};
      vt[2] = '{0, 2, {16{8'hE8}}};
      vt[3] = '{0, 4, {8{16'hEE88}}};
      vt[4] = '{3, 3, {{64{1'b1}}, {64{1'b0}}}};
      vt[5] = '{3, 0, {32{4'hA}}};
      if0.start = 1'b0;
      if3.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_x0", 128'(if0.x), 0);
      chk("rst_busy0", 128'(if0.busy), 0);
      chk("rst_done0", 128'(if0.done), 0);
      chk("rst_tt0", if0.tt, 0);
      chk("rst_x3", 128'(if3.x), 0);
      chk("rst_tt3", if3.tt, 0);
`ifdef TT_CAPTURE_CMP_EN
      chk("rst_match0", 128'(if0.match), 0);
`endif
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_busy0", 128'(if0.busy), 0);
      chk("idle_busy3", 128'(if3.busy), 0);
      for (int i = 0; i < 6; i++) begin
         if (vt[i].inst == 0) sel0 = vt[i].fsel;
         else sel3 = vt[i].fsel;
         lat = vt[i].inst == 0 ? 0 : 3;
         sweep(vt[i].inst, 0, done_at, busy_cnt, ndone, got);
         chk($sformatf("v%0d_tt", i), got, vt[i].exp_tt);
         chk($sformatf("v%0d_done_at", i), 128'(done_at), 128'(129 + lat));
         chk($sformatf("v%0d_busy_before_done", i), 128'(busy_cnt), 128'(128 + lat));
         chk($sformatf("v%0d_done_pulses", i), 128'(ndone), 1);
         chk($sformatf("v%0d_tt_held", i), ttv(vt[i].inst), vt[i].exp_tt);
`ifdef TT_CAPTURE_CMP_EN
         if (vt[i].inst == 0 && (vt[i].fsel == 2 || vt[i].fsel == 4))
            chk($sformatf("v%0d_match", i), 128'(if0.match), 128'(vt[i].fsel == 2));
`endif
      end
      // start while busy is ignored
      sel0 = 2;
      sweep(0, 50, done_at, busy_cnt, ndone, got);
      chk("ign_done_pulses", 128'(ndone), 1);
      chk("ign_done_at", 128'(done_at), 129);
      chk("ign_tt", got, {16{8'hE8}});
      // asynchronous reset mid-sweep
      sel0 = 0;
      @(negedge clk) if0.start = 1'b1;
      @(posedge clk) #1 if0.start = 1'b0;
      repeat (59) @(posedge clk);
      #2;
      chk("pre_rst_busy", 128'(if0.busy), 1);
      chk("pre_rst_x", 128'(if0.x), 59);
      rst_n = 1'b0;
      #1;
      chk("arst_x", 128'(if0.x), 0);
      chk("arst_busy", 128'(if0.busy), 0);
      chk("arst_done", 128'(if0.done), 0);
      chk("arst_tt0", if0.tt, 0);
      chk("arst_tt3", if3.tt, 0);
      @(negedge clk) rst_n = 1'b1;
      sweep(0, 0, done_at, busy_cnt, ndone, got);
      chk("post_rst_tt", got, {32{4'hA}});
      chk("post_rst_done_at", 128'(done_at), 129);
      // back-to-back: start in the DONE cycle
      sel0 = 2;
      d_base = d0;
      @(negedge clk) if0.start = 1'b1;
      @(posedge clk) #1 if0.start = 1'b0;
      for (n = 1; n <= 200 && !if0.done; n++) @(posedge clk) #1;
      chk("b2b_first_done_at", 128'(n), 129);
      chk("b2b_first_tt", if0.tt, {16{8'hE8}});
      if0.start = 1'b1;
      sel0 = 1;
      @(posedge clk) #1 if0.start = 1'b0;
      chk("b2b_no_repeat_done", 128'(if0.done), 0);
      chk("b2b_busy", 128'(if0.busy), 1);
      chk("b2b_tt_cleared", if0.tt, 0);
      for (m = 1; m <= 200 && !if0.done; m++) @(posedge clk) #1;
      chk("b2b_second_done_at", 128'(m), 129);
      chk("b2b_second_tt", if0.tt, {32{4'h5}});
      repeat (5) @(posedge clk);
      #1;
      chk("b2b_done_pulses", 128'(d0 - d_base), 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
